bcd_word_adder: RTL
===================

# bcd_word_adder

Sequential multi-digit BCD adder that accepts two packed BCD operands through a valid/ready handshake and ripples them one digit per clock through the team's existing single-digit combinational `adder` (4-bit digit in1/in2, cin, out, cout). It sits directly upstream of `adder` and feeds it one digit pair per cycle. It also sits downstream of the operand source, registering the per-digit results into a full-width sum. Operands containing a non-BCD nibble are rejected with an error flag instead of being summed.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low (one clock, no other reset)
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands
- a  in  4*DIGITS  operand A, digit 0 in bits [3:0]
- b  in  4*DIGITS  operand B, same packing
- cin  in  1  carry into digit 0
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  4*DIGITS  BCD sum, same packing
- cout  out  1  carry out of digit DIGITS-1
- err  out  1  operand contained a nibble > 9; valid with out_valid

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - ADD: in_ready=0; digit index idx counts 0..DIGITS-1.
  - DONE: out_valid=1.
- IDLE to ADD:
  - Accept when in_valid&&in_ready.
  - Latch a, b and cin into operand registers.
  - Clear sum register and idx; carry register := cin.
- IDLE to DONE (error path):
  - Taken instead of ADD when any nibble of a or b at acceptance exceeds 9.
  - err := 1, sum := 0, cout := 0.
- ADD cycle:
  - Drive `adder` with in1=A[idx], in2=B[idx], cin=carry register.
  - Register out into sum digit idx; carry register := cout.
  - idx increments each cycle.
- ADD to DONE: at idx==DIGITS-1, after registering that digit; cout := final carry; err := 0.
- DONE to IDLE: on out_valid&&out_ready.
  - sum, cout and err hold their values until the next acceptance.
- While out_ready is low in DONE, out_valid, sum, cout and err are stable.
- Input side: in_ready is deasserted in ADD and DONE; no input bypass.
- Output side: a result cannot be consumed in the same cycle a new operand is accepted.
- Arithmetic: each digit is exact BCD 0–9; sum is the decimal sum modulo 10^DIGITS; cout=1 iff the total ≥ 10^DIGITS.

## Timing
- Reset values (asynchronous, while rst_n=0): state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, err=0, idx=0, carry=0.
- Normal-path latency: acceptance at edge T gives out_valid=1 in the cycle after edge T+DIGITS (DIGITS ADD cycles).
- Error-path latency: out_valid=1 in the cycle after the acceptance edge.
- Throughput: one operation per DIGITS+2 cycles at best (accept, DIGITS adds, handshake out).
- Reset asserted mid-ADD or in DONE: the operation is abandoned with no result and all outputs return to reset values immediately.
- in_valid toggling while not in IDLE is ignored; a and b are sampled only at acceptance.
- DIGITS=1 edge case: one ADD cycle, then DONE.

## Structure
- Shared include `bcd_defs.vh` holds:
  - BCD_W=4
  - BCD_MAX=9
  - state encodings S_IDLE/S_ADD/S_DONE
- One sub-module: the existing `adder`, instantiated once and reused across digits.
- Nibble range check: a generate loop producing a DIGITS-wide bad-nibble vector, OR-reduced.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- DIGITS=4:
  - a=16'h1234, b=16'h5678, cin=0 → sum=16'h6912, cout=0, err=0; out_valid exactly 4 cycles after the acceptance edge.
  - a=16'h9999, b=16'h0001, cin=0 → sum=16'h0000, cout=1 (full ripple of carries).
  - a=16'h9999, b=16'h9999, cin=1 → sum=16'h9999, cout=1.
  - a=16'h12A4, b=16'h0000 → err=1, sum=0, cout=0, out_valid 1 cycle after acceptance.
  - Backpressure: out_ready held low 5 cycles in DONE → outputs stable throughout and in_ready=0; on release, IDLE next cycle.
  - rst_n pulsed low during the 2nd ADD cycle → out_valid never rises; all outputs zero; the next operand 16'h0005+16'h0005 gives 16'h0010.

Source files
------------

// File: rtl/bcd_word_adder_pkg.sv
// Shared definitions for the sequential BCD word adder and its digit adder.
package bcd_word_adder_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_word_adder_adder.sv
// Single-digit combinational BCD adder: in1 + in2 + cin, decimal-corrected.
// Operands are assumed to already be valid BCD digits (0..9).
module adder
  import bcd_word_adder_pkg::*;
(
  input  logic [BCD_W-1:0] in1,
  input  logic [BCD_W-1:0] in2,
  input  logic             cin,
  output logic [BCD_W-1:0] out,
  output logic             cout
);

  logic [BCD_W:0] raw;
  logic [BCD_W:0] adj;

  // Binary add, then add 6 when the digit overflows past 9 to wrap into BCD.
  always_comb begin
    raw  = {1'b0, in1} + {1'b0, in2} + {{BCD_W{1'b0}}, cin};
    adj  = raw;
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      adj  = raw + (BCD_W+1)'(6);
      cout = 1'b1;
    end
    out = adj[BCD_W-1:0];
  end

endmodule

// File: rtl/bcd_word_adder.sv
// Sequential multi-digit BCD adder: accepts a packed operand pair, ripples
// one digit per clock through a single shared digit adder, and presents the
// full-width sum through a valid/ready handshake. Non-BCD operands are
// rejected with err instead of being summed.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for operands, in_ready=1
// S_ADD  | rippling digit idx through the digit adder, 0..DIGITS-1
// S_DONE | result (or error) presented, out_valid=1 until out_ready
module bcd_word_adder
  import bcd_word_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                  cout,
  output logic                  err
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t                    state;
  logic [BCD_W*DIGITS-1:0]   op_a;
  logic [BCD_W*DIGITS-1:0]   op_b;
  logic                      carry;
  logic [IDX_W-1:0]          idx;

  logic [DIGITS-1:0]         bad;
  logic                      bad_any;

  logic [BCD_W-1:0]          dig_a;
  logic [BCD_W-1:0]          dig_b;
  logic [BCD_W-1:0]          dig_sum;
  logic                      dig_cout;

  // Flag every digit position where either incoming operand holds a nibble above 9.
  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    assign bad[g] = (a[BCD_W*g +: BCD_W] > BCD_MAX) || (b[BCD_W*g +: BCD_W] > BCD_MAX);
  end
  assign bad_any = |bad;

  assign dig_a = op_a[BCD_W*idx +: BCD_W];
  assign dig_b = op_b[BCD_W*idx +: BCD_W];

  adder u_adder (
    .in1  (dig_a),
    .in2  (dig_b),
    .cin  (carry),
    .out  (dig_sum),
    .cout (dig_cout)
  );

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            if (bad_any) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              err       <= 1'b1;
            end else begin
              state <= S_ADD;
              op_a  <= a;
              op_b  <= b;
              carry <= cin;
              idx   <= '0;
              err   <= 1'b0;
            end
          end
        end
        S_ADD: begin
          sum[BCD_W*idx +: BCD_W] <= dig_sum;
          carry                   <= dig_cout;
          if (idx == IDX_LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            cout      <= dig_cout;
            err       <= 1'b0;
            idx       <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
